// File: rtl/mdr_unit.sv
// mdr_unit - memory data register with a handshaked memory sequencer.
//
// Holds the datapath's memory data register and runs single memory
// accesses on its behalf: reads with sub-word lane extraction and sign/zero
// extension, writes with lane-replicated store data and byte enables.
//
// Optional feature macro: MDR_TIMEOUT_EN
//   defined   - a wait-state counter aborts an access after TIMEOUT cycles
//               without mem_ready and pulses err.
//   undefined - accesses wait indefinitely; err is tied low.
//
// Parameters:
//   WIDTH    data width, multiple of 16 and at least 32
//   TIMEOUT  wait cycles before abort (1..255), timeout build only
//
// Ports:
//   clock, clear        rising-edge clock, asynchronous active-low reset
//   BusMuxOut, MDRin    datapath bus value and register load strobe
//   Read, Write         start a memory read / write (accepted in IDLE only)
//   size, sign_ext      access size (00 byte, 01 half, 1x word), read extension
//   byte_off            byte offset of the sub-word field within the word
//   mem_*               memory port (request, write enable, data, byte enables)
//   MDRout              register contents
//   busy, done, err     access in flight, completion pulse, timeout pulse
//   dbg_state           current sequencer state (IDLE=0, RD_WAIT=1, WR_WAIT=2)
//
// Memory handshake: mem_req acts as "valid". Once raised it is held, together
// with mem_we/mem_be/mem_wdata, until the clock edge that samples
// mem_ready=1 (transfer complete) or a timeout abort; mem_req, mem_we and
// mem_be drop on that same edge. mem_ready is ignored while no request is
// outstanding.

module mdr_unit #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                       clock,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           BusMuxOut,
  input  logic                       MDRin,
  input  logic                       Read,
  input  logic                       Write,
  input  logic [1:0]                 size,
  input  logic                       sign_ext,
  input  logic [$clog2(WIDTH/8)-1:0] byte_off,
  input  logic [WIDTH-1:0]           mem_rdata,
  input  logic                       mem_ready,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [WIDTH-1:0]           mem_wdata,
  output logic [WIDTH/8-1:0]         mem_be,
  output logic [WIDTH-1:0]           MDRout,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [1:0]                 dbg_state
);

  localparam int NB = WIDTH / 8;
  localparam int OW = $clog2(NB);

  if ((WIDTH % 16) != 0 || WIDTH < 32) begin : g_bad_width
    $error("mdr_unit: WIDTH must be a multiple of 16 and at least 32");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mdr_unit: TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mdr_q, mdr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [NB-1:0]    be_q, be_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       size_q, size_d;
  logic             sext_q, sext_d;
  logic [OW-1:0]    off_q, off_d;
`ifdef MDR_TIMEOUT_EN
  logic [7:0]       cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // Half-word accesses are aligned: the low offset bit is forced to zero.
  function automatic logic [OW-1:0] half_off(input logic [OW-1:0] off);
    return {off[OW-1:1], 1'b0};
  endfunction

  function automatic logic [NB-1:0] lane_be(input logic [1:0] sz,
                                            input logic [OW-1:0] off);
    logic [NB-1:0] be;
    case (sz)
      2'b00:   be = NB'(1) << off;
      2'b01:   be = NB'(3) << half_off(off);
      default: be = {NB{1'b1}};
    endcase
    return be;
  endfunction

  // Store data is replicated across every lane so the memory can pick the
  // enabled lanes without needing the offset itself.
  function automatic logic [WIDTH-1:0] store_data(input logic [WIDTH-1:0] d,
                                                  input logic [1:0] sz);
    logic [WIDTH-1:0] r;
    case (sz)
      2'b00:   r = {NB{d[7:0]}};
      2'b01:   r = {(NB/2){d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] extract_field(input logic [WIDTH-1:0] d,
                                                     input logic [1:0] sz,
                                                     input logic sx,
                                                     input logic [OW-1:0] off);
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] r;
    sh = '0;
    case (sz)
      2'b00: begin
        sh = d >> {off, 3'b000};
        r  = {{(WIDTH-8){sx & sh[7]}}, sh[7:0]};
      end
      2'b01: begin
        sh = d >> {half_off(off), 3'b000};
        r  = {{(WIDTH-16){sx & sh[15]}}, sh[15:0]};
      end
      default: r = d;
    endcase
    return r;
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    mdr_d   = mdr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    req_d   = req_q;
    we_d    = we_q;
    done_d  = 1'b0;
    size_d  = size_q;
    sext_d  = sext_q;
    off_d   = off_q;
`ifdef MDR_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (Read) begin
          size_d  = size;
          sext_d  = sign_ext;
          off_d   = byte_off;
          req_d   = 1'b1;
          we_d    = 1'b0;
          be_d    = lane_be(size, byte_off);
          state_d = RD_WAIT;
`ifdef MDR_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else if (Write) begin
          size_d  = size;
          sext_d  = sign_ext;
          off_d   = byte_off;
          req_d   = 1'b1;
          we_d    = 1'b1;
          be_d    = lane_be(size, byte_off);
          wdata_d = store_data(mdr_q, size);
          state_d = WR_WAIT;
`ifdef MDR_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else if (MDRin) begin
          mdr_d = BusMuxOut;
        end
      end

      RD_WAIT, WR_WAIT: begin
        if (mem_ready) begin
          if (state_q == RD_WAIT) begin
            mdr_d = extract_field(mem_rdata, size_q, sext_q, off_q);
          end
          req_d   = 1'b0;
          we_d    = 1'b0;
          be_d    = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
`ifdef MDR_TIMEOUT_EN
          // This edge is the TIMEOUT-th waiting cycle: give up.
          if (cnt_q == 8'(TIMEOUT - 1)) begin
            req_d   = 1'b0;
            we_d    = 1'b0;
            be_d    = '0;
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
`endif
        end
      end

      default: begin
        req_d   = 1'b0;
        we_d    = 1'b0;
        be_d    = '0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      mdr_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      off_q   <= '0;
`ifdef MDR_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mdr_q   <= mdr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      req_q   <= req_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      off_q   <= off_d;
`ifdef MDR_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign MDRout    = mdr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;
`ifdef MDR_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_mdr_unit.sv
// Directed bench for mdr_unit (WIDTH=32, TIMEOUT=15). Inputs are driven 1ns
// after each rising edge, outputs are sampled at that same point.
`timescale 1ns/1ps

module tb_mdr_unit;

  localparam int W  = 32;
  localparam int NB = W / 8;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic clear;
  always #5 clock = ~clock;

  logic [W-1:0]  BusMuxOut;
  logic          MDRin, Read, Write;
  logic [1:0]    size;
  logic          sign_ext;
  logic [1:0]    byte_off;
  logic [W-1:0]  mem_rdata;
  logic          mem_ready;
  logic          mem_req, mem_we;
  logic [W-1:0]  mem_wdata;
  logic [NB-1:0] mem_be;
  logic [W-1:0]  MDRout;
  logic          busy, done, err;
  logic [1:0]    dbg_state;

  mdr_unit #(.WIDTH(W), .TIMEOUT(15)) dut (
    .clock     (clock),
    .clear     (clear),
    .BusMuxOut (BusMuxOut),
    .MDRin     (MDRin),
    .Read      (Read),
    .Write     (Write),
    .size      (size),
    .sign_ext  (sign_ext),
    .byte_off  (byte_off),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .MDRout    (MDRout),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_miss = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    MDRin = 0; Read = 0; Write = 0;
  endtask

  task automatic load_mdr(input logic [W-1:0] v);
    BusMuxOut = v; MDRin = 1;
    tick();
    MDRin = 0;
    check("mdrin_load", MDRout, v);
  endtask

  // Read with 'waits' not-ready cycles, result checked against the queue.
  task automatic do_read(input string tag, input logic [1:0] sz, input logic sx,
                         input logic [1:0] off, input logic [W-1:0] rd,
                         input int waits, input logic [NB-1:0] exp_be,
                         input logic [W-1:0] exp_mdr);
    exp_q.push_back(exp_mdr);
    size = sz; sign_ext = sx; byte_off = off; Read = 1;
    tick();
    Read = 0;
    check({tag, "_req"}, {31'd0, mem_req}, 32'd1);
    check({tag, "_we"},  {31'd0, mem_we},  32'd0);
    check({tag, "_be"},  {28'd0, mem_be},  {28'd0, exp_be});
    repeat (waits) tick();
    mem_rdata = rd; mem_ready = 1;
    tick();
    mem_ready = 0;
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_reqoff"}, {31'd0, mem_req}, 32'd0);
    check({tag, "_mdr"}, MDRout, exp_q.pop_front());
    tick();
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  task automatic do_write(input string tag, input logic [1:0] sz, input logic [1:0] off,
                          input int waits, input logic [W-1:0] exp_wdata,
                          input logic [NB-1:0] exp_be, input logic [W-1:0] mdr_now);
    size = sz; byte_off = off; Write = 1;
    tick();
    Write = 0;
    check({tag, "_we"},    {31'd0, mem_we}, 32'd1);
    check({tag, "_wdata"}, mem_wdata, exp_wdata);
    check({tag, "_be"},    {28'd0, mem_be}, {28'd0, exp_be});
    repeat (waits) tick();
    check({tag, "_held"},  {31'd0, mem_req}, 32'd1);
    mem_ready = 1;
    tick();
    mem_ready = 0;
    check({tag, "_done"},  {31'd0, done}, 32'd1);
    check({tag, "_beoff"}, {28'd0, mem_be}, 32'd0);
    check({tag, "_weoff"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_mdr"},   MDRout, mdr_now);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int n;
    int dones;
    idle_inputs();
    BusMuxOut = '0; size = 0; sign_ext = 0; byte_off = 0;
    mem_rdata = '0; mem_ready = 0;
    clear = 0;
    repeat (3) tick();
    check("rst_mdr",   MDRout, 32'd0);
    check("rst_req",   {31'd0, mem_req}, 32'd0);
    check("rst_be",    {28'd0, mem_be}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_flags", {28'd0, busy, done, err, mem_we}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    clear = 1;
    tick();

    // Reset in the middle of a read: everything drops immediately.
    size = 2; Read = 1;
    tick();
    Read = 0;
    check("midrst_busy", {31'd0, busy}, 32'd1);
    check("midrst_state", {30'd0, dbg_state}, 32'd1);
    #2 clear = 0;
    #1;
    check("midrst_req",   {31'd0, mem_req}, 32'd0);
    check("midrst_flags", {28'd0, busy, done, err, mem_we}, 32'd0);
    check("midrst_be",    {28'd0, mem_be}, 32'd0);
    check("midrst_state2", {30'd0, dbg_state}, 32'd0);
    tick();
    clear = 1;
    mem_rdata = 32'hFFFF_FFFF; mem_ready = 1;
    tick();
    mem_ready = 0;
    check("midrst_ignready_done", {31'd0, done}, 32'd0);
    check("midrst_ignready_mdr", MDRout, 32'd0);
    check("midrst_ignready_req", {31'd0, mem_req}, 32'd0);

    // Store: byte lane 2, two wait states, MDR unchanged.
    load_mdr(32'h1234_5678);
    do_write("wr_b2", 2'b00, 2'd2, 2, 32'h7878_7878, 4'b0100, 32'h1234_5678);

    // Sub-word reads, zero-wait memory.
    do_read("rd_b3_sx", 2'b00, 1'b1, 2'd3, 32'h80FF_0000, 0, 4'b1000, 32'hFFFF_FF80);
    do_read("rd_b3_zx", 2'b00, 1'b0, 2'd3, 32'h80FF_0000, 0, 4'b1000, 32'h0000_0080);
    do_read("rd_h3_zx", 2'b01, 1'b0, 2'd3, 32'hBEEF_1234, 0, 4'b1100, 32'h0000_BEEF);
    do_read("rd_h3_sx", 2'b01, 1'b1, 2'd3, 32'hBEEF_1234, 1, 4'b1100, 32'hFFFF_BEEF);
    do_read("rd_h0_sx", 2'b01, 1'b1, 2'd0, 32'hBEEF_1234, 0, 4'b0011, 32'h0000_1234);
    do_read("rd_b1_sx", 2'b00, 1'b1, 2'd1, 32'h0000_F100, 3, 4'b0010, 32'hFFFF_FFF1);
    do_read("rd_word",  2'b10, 1'b1, 2'd1, 32'hCAFE_BABE, 2, 4'b1111, 32'hCAFE_BABE);

    // Half store from the odd offset 1 -> aligned lanes 1:0; word store as-is.
    do_write("wr_h1", 2'b01, 2'd1, 0, 32'hBABE_BABE, 4'b0011, 32'hCAFE_BABE);
    do_write("wr_w",  2'b11, 2'd2, 1, 32'hCAFE_BABE, 4'b1111, 32'hCAFE_BABE);

    // Read and Write together, then Read again while busy.
    size = 2; Read = 1; Write = 1;
    tick();
    Write = 0;
    check("rw_we",  {31'd0, mem_we}, 32'd0);
    check("rw_req", {31'd0, mem_req}, 32'd1);
    tick();
    Read = 0;
    mem_rdata = 32'h1122_3344; mem_ready = 1;
    tick();
    mem_ready = 0;
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) dones++;
      if (i < 4) tick();
    end
    check("rw_one_done", dones, 32'd1);
    check("rw_mdr", MDRout, 32'h1122_3344);
    check("rw_idle_req", {31'd0, mem_req}, 32'd0);

    // MDRin while busy is ignored.
    size = 2; Read = 1;
    tick();
    Read = 0; BusMuxOut = 32'hDEAD_0000; MDRin = 1;
    tick();
    MDRin = 0;
    check("busy_mdrin_ign", MDRout, 32'h1122_3344);
    mem_rdata = 32'h0BAD_F00D; mem_ready = 1;
    tick();
    mem_ready = 0;
    check("busy_rd_mdr", MDRout, 32'h0BAD_F00D);
    tick();

`ifdef MDR_TIMEOUT_EN
    // No ready at all: abort after 15 waiting cycles.
    size = 2; Read = 1;
    tick();
    Read = 0;
    n = 0;
    while (mem_req && n < 40) begin
      tick();
      n++;
    end
    check("to_wait_cycles", n, 32'd15);
    check("to_err", {31'd0, err}, 32'd1);
    check("to_no_done", {31'd0, done}, 32'd0);
    check("to_mdr", MDRout, 32'h0BAD_F00D);
    check("to_be", {28'd0, mem_be}, 32'd0);
    tick();
    check("to_err_pulse", {31'd0, err}, 32'd0);

    // Ready on the 15th waiting cycle wins over the timeout.
    size = 2; Read = 1;
    tick();
    Read = 0;
    repeat (14) tick();
    check("to_edge_req", {31'd0, mem_req}, 32'd1);
    mem_rdata = 32'h5555_AAAA; mem_ready = 1;
    tick();
    mem_ready = 0;
    check("to_edge_done", {31'd0, done}, 32'd1);
    check("to_edge_err",  {31'd0, err}, 32'd0);
    check("to_edge_mdr",  MDRout, 32'h5555_AAAA);
    tick();
`else
    // Without the timeout the access waits as long as needed.
    size = 2; Read = 1;
    tick();
    Read = 0;
    n = 0;
    while (mem_req && n < 30) begin
      tick();
      n++;
      if (err) check("nto_err", {31'd0, err}, 32'd0);
    end
    check("nto_still_waiting", n, 32'd30);
    check("nto_err_low", {31'd0, err}, 32'd0);
    mem_rdata = 32'h5555_AAAA; mem_ready = 1;
    tick();
    mem_ready = 0;
    check("nto_done", {31'd0, done}, 32'd1);
    check("nto_mdr",  MDRout, 32'h5555_AAAA);
    tick();
`endif

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin : watchdog
    #200000;
    n_miss++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
